sipo_loader: RTL and testbench
==============================

SIPO_LOADER -- requirements
Module: sipo_loader

Interface
REQ-001 Parameter WIDTH, default 8: word width in bits, which sets the width of word_out.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first serial bit lands in word_out[WIDTH-1]; 0 means it lands in word_out[0].
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 res  input  1: reset, synchronous and active-high.
REQ-005 ser_in  input  1: serial data bit.
REQ-006 ser_valid  input  1: ser_in is sampled on this edge.
REQ-007 sof  input  1: start-of-word, qualified by ser_valid; the bit sampled with sof is bit 0 of a new word.
REQ-008 word_out  output  WIDTH: assembled parallel word, fed to the downstream rotate register.
REQ-009 word_valid  output  1: word_out holds an unconsumed word.
REQ-010 word_ready  input  1: downstream accepts word_out on an edge where word_valid and word_ready are both 1.
REQ-011 bit_cnt  output  clog2(WIDTH)+1: number of bits collected in the current partial word.
REQ-012 ovf  output  1: sticky overflow flag.
REQ-013 ovf_clr  input  1: clears ovf.

Function
REQ-014 Collector FSM states: IDLE (bit_cnt=0) and FILL (1..WIDTH-1 bits).
- IDLE to FILL on ser_valid.
- FILL to IDLE on the WIDTH-th bit, or on res.
REQ-015 Each ser_valid edge shifts ser_in into the internal shift register and increments bit_cnt; cycles with ser_valid=0 hold all state.
REQ-016 MSB_FIRST=1: shift left, inserting at bit 0; MSB_FIRST=0: shift right, inserting at bit WIDTH-1.
REQ-017 sof=1 with ser_valid=1 discards any partial word; this bit counts as bit 0 and bit_cnt becomes 1, with no ovf and no output.
REQ-018 On the edge sampling the WIDTH-th bit, the completed word (including that bit) is transferred to the word_out register and bit_cnt returns to 0.
REQ-019 word_valid rises at the same edge as the transfer, so latency is 1 cycle from the last bit sample to visible word_out/word_valid.
REQ-020 Back-to-back streaming at one bit per cycle gives one word every WIDTH cycles, with no bubble required.
REQ-021 word_out and word_valid stay stable while word_valid=1 and word_ready=0.
REQ-022 Accept with no completion on the same edge: word_valid goes to 0 and word_out holds its old value.
REQ-023 Accept and completion on the same edge: the new word loads, word_valid stays 1, and ovf is not set.
REQ-024 Completion while word_valid=1 and word_ready=0: the new word is dropped, the old word is retained, ovf is set to 1, and collection continues from bit_cnt=0.
REQ-025 ovf_clr clears ovf; if ovf_clr and a new overflow occur on the same edge, ovf ends at 1.
REQ-026 word_ready while word_valid=0 has no effect.

Reset
REQ-027 res=1 at an edge sets word_out=0, word_valid=0, bit_cnt=0, ovf=0 and FSM=IDLE; ser_valid and word_ready are ignored on that edge.
REQ-028 Reset mid-word discards the partial word; the first ser_valid after reset deasserts is bit 0.
REQ-029 No output changes except on a clk rising edge, including during reset.

Structure
REQ-030 A shared package holds the FSM state encoding (IDLE, FILL) and the WIDTH default constant, which is also used by the downstream rotate register.
REQ-031 One sub-module, sipo_out_reg, holds word_out, word_valid and the ovf logic; the collector FSM and shift register sit at the top level.
REQ-032 Target size: 120–400 lines of RTL; no latches; all state in flip-flops clocked by clk.

Verification
REQ-033 MSB_FIRST=1: feed 1,0,1,0,0,1,0,1 on consecutive cycles with word_ready=1 -> word_out=8'hA5 and word_valid=1 starting one cycle after the 8th bit, then word_valid=0 the next cycle.
REQ-034 MSB_FIRST=0: feed the same bits -> word_out=8'hA5 reversed = 8'hA5 (palindrome check); then feed 1,1,0,0,0,0,0,0 -> word_out=8'h03.
REQ-035 word_ready=0; stream 8'h3C then 8'hF0 continuously -> word_out stays 8'h3C, ovf=1 one cycle after the 16th bit; ovf_clr pulse -> ovf=0.
REQ-036 Streaming with word_ready asserted exactly on the completion edge of word 2 (8'h55 then 8'hAA) -> word_valid stays high, word_out changes from 8'h55 to 8'hAA, ovf=0.
REQ-037 After 5 bits, pulse sof with ser_in=1 and then feed 7 more bits 0 -> bit_cnt=1 after sof; output word is 8'h80 (MSB_FIRST=1).
REQ-038 res=1 after 3 bits, then release and feed 8'hC3 -> word_out=8'hC3 with no residue from the earlier bits; all outputs are 0 during reset.

Source files
------------

// File: rtl/sipo_loader_pkg.sv
// Shared definitions for the serial-to-parallel loader and the downstream
// rotate register that consumes its words.
package sipo_loader_pkg;

  // Default word width, shared with the downstream rotate register.
  localparam int SIPO_WIDTH = 8;

  // Collector state: IDLE holds no bits, FILL holds 1..WIDTH-1 bits.
  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } sipo_state_e;

endpackage

// File: rtl/sipo_out_reg.sv
// Output stage: holds the assembled word, its valid flag and the sticky
// overflow flag. A completed word is dropped when the previous one is still
// pending and not being accepted on the same edge.
module sipo_out_reg
  import sipo_loader_pkg::*;
#(
  parameter int WIDTH = SIPO_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_ready,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             ovf
);

  logic accept;
  logic drop;

  // Handshake decode: a completion is lost only against a stalled pending word.
  always_comb begin
    accept = word_valid & word_ready;
    drop   = load & word_valid & ~word_ready;
  end

  // Word/valid register; a load on an accepting edge keeps valid high.
  always_ff @(posedge clk) begin
    if (res) begin
      word_out   <= '0;
      word_valid <= 1'b0;
    end else if (load && !drop) begin
      word_out   <= word_in;
      word_valid <= 1'b1;
    end else if (accept) begin
      word_valid <= 1'b0;
    end
  end

  // Sticky overflow; a new overflow wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf <= 1'b0;
    end else if (drop) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_loader.sv
// Serial-in parallel-out loader: collects WIDTH serial bits into a word and
// hands it to the output register with a valid/ready handshake.
//
// state | meaning
// IDLE  | no bits collected, bit_cnt = 0
// FILL  | partial word held, bit_cnt = 1..WIDTH-1
module sipo_loader
  import sipo_loader_pkg::*;
#(
  parameter int WIDTH     = SIPO_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic                       ser_in,
  input  logic                       ser_valid,
  input  logic                       sof,
  output logic [WIDTH-1:0]           word_out,
  output logic                       word_valid,
  input  logic                       word_ready,
  output logic [$clog2(WIDTH):0]     bit_cnt,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_e      state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shifted;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_bit;
  logic             done;

  // Shift direction decides where the first bit of a word ends up.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {shreg_q[WIDTH-2:0], ser_in};
    end else begin
      shifted = {ser_in, shreg_q[WIDTH-1:1]};
    end
    last_bit = ser_valid & ~sof & (state_q == FILL) & (cnt_q == LAST);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; sof always (re)starts a word in FILL.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (ser_valid) state_d = FILL;
      FILL: if (last_bit)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values. On sof the stale bits stay in the shifter but are
  // pushed out before the restarted word can complete.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done    = 1'b0;
    if (ser_valid) begin
      shreg_d = shifted;
      if (sof) begin
        cnt_d = CW'(1);
      end else if (last_bit) begin
        cnt_d = '0;
        done  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge clk) begin
    if (res) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bit_cnt = cnt_q;

  sipo_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .res       (res),
    .load      (done),
    .word_in   (shifted),
    .word_ready(word_ready),
    .ovf_clr   (ovf_clr),
    .word_out  (word_out),
    .word_valid(word_valid),
    .ovf       (ovf)
  );

endmodule

// File: tb/tb_sipo_loader.sv
// Bench for sipo_loader: an MSB-first and an LSB-first instance share the
// same stimulus and are compared against a queue-based reference model.
module tb_sipo_loader;

  localparam int W = 8;

  logic clk = 1'b0;
  logic res, ser_in, ser_valid, sof, word_ready, ovf_clr;
  logic [W-1:0] wo_m, wo_l;
  logic         wv_m, wv_l, ovf_m, ovf_l;
  logic [3:0]   bc_m, bc_l;

  int n_cmp = 0;
  int n_err = 0;

  bit         q[$];
  logic [7:0] exp_word_m, exp_word_l;
  logic       exp_valid, exp_ovf;

  always #5 clk = ~clk;

  sipo_loader #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .res(res), .ser_in(ser_in), .ser_valid(ser_valid), .sof(sof),
    .word_out(wo_m), .word_valid(wv_m), .word_ready(word_ready),
    .bit_cnt(bc_m), .ovf(ovf_m), .ovf_clr(ovf_clr));

  sipo_loader #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .res(res), .ser_in(ser_in), .ser_valid(ser_valid), .sof(sof),
    .word_out(wo_l), .word_valid(wv_l), .word_ready(word_ready),
    .bit_cnt(bc_l), .ovf(ovf_l), .ovf_clr(ovf_clr));

  // Reference model: a word is the list of received bits in arrival order.
  task automatic model_edge(input logic r, sv, si, sf, rdy, clr);
    bit done;
    bit drop;
    logic [7:0] wm, wl;
    wm = '0;
    wl = '0;
    if (r) begin
      q.delete();
      exp_word_m = '0; exp_word_l = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
      return;
    end
    done = 1'b0;
    if (sv) begin
      if (sf) q.delete();
      q.push_back(si);
      if (!sf && q.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = q[i];
          wl[i]     = q[i];
        end
        q.delete();
      end
    end
    drop = done && exp_valid && !rdy;
    if (done && !drop) begin
      exp_word_m = wm; exp_word_l = wl; exp_valid = 1'b1;
    end else if (exp_valid && rdy) begin
      exp_valid = 1'b0;
    end
    if (drop) exp_ovf = 1'b1;
    else if (clr) exp_ovf = 1'b0;
  endtask

  // One clock: apply inputs, advance the model at the edge, settle 1 time unit.
  task automatic step(input logic r, sv, si, sf, rdy, clr);
    res = r; ser_valid = sv; ser_in = si; sof = sf; word_ready = rdy; ovf_clr = clr;
    @(posedge clk);
    model_edge(r, sv, si, sf, rdy, clr);
    #1;
  endtask

  // Sends w MSB-first as consecutive bits; the last bit may use its own ready/clr.
  task automatic send_word(input logic [7:0] w, input logic rdy, rdy_last, clr_last);
    for (int i = W - 1; i >= 0; i--)
      step(1'b0, 1'b1, w[i], 1'b0, (i == 0) ? rdy_last : rdy, (i == 0) ? clr_last : 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, ovf_m, bc_m, wo_m, wv_l, ovf_l, bc_l, wo_l} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got m=%b/%b/%0d/%h l=%b/%b/%0d/%h want all 0",
               wv_m, ovf_m, bc_m, wo_m, wv_l, ovf_l, bc_l, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_lsb_order();
    send_word(8'hA5, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, wv_l, wo_l} !== {1'b1, 8'hA5, 1'b1, 8'hA5}) begin
      n_err++;
      $display("FAIL a5_word: got m=%b/%h l=%b/%h want 1/a5 1/a5", wv_m, wo_m, wv_l, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, wv_l} !== 2'b00) begin
      n_err++;
      $display("FAIL a5_consumed: got valid m=%b l=%b want 0", wv_m, wv_l);
    end
    send_word(8'hC0, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({wo_m, wo_l} !== {8'hC0, 8'h03}) begin
      n_err++;
      $display("FAIL bit_order: got m=%h l=%h want c0 03", wo_m, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_overflow();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(8'h3C, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, ovf_m} !== {1'b1, 8'h3C, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_first_word: got %b/%h/%b want 1/3c/0", wv_m, wo_m, ovf_m);
    end
    send_word(8'hF0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, ovf_m, ovf_l, bc_m} !== {1'b1, 8'h3C, 1'b1, 1'b1, 4'd0}) begin
      n_err++;
      $display("FAIL ovf_set: got valid=%b word=%h ovf=%b/%b cnt=%0d want 1/3c/1/1/0",
               wv_m, wo_m, ovf_m, ovf_l, bc_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf_m, ovf_l, wv_m} !== 3'b001) begin
      n_err++;
      $display("FAIL ovf_clr: got ovf=%b/%b valid=%b want 0/0/1", ovf_m, ovf_l, wv_m);
    end
    send_word(8'h81, 1'b0, 1'b0, 1'b1);
    n_cmp++;
    if ({ovf_m, wo_m} !== {1'b1, 8'h3C}) begin
      n_err++;
      $display("FAIL ovf_set_beats_clr: got ovf=%b word=%h want 1/3c", ovf_m, wo_m);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    n_cmp++;
    if ({ovf_m, wv_m, wo_m} !== {1'b0, 1'b0, 8'h3C}) begin
      n_err++;
      $display("FAIL ovf_drain: got ovf=%b valid=%b word=%h want 0/0/3c", ovf_m, wv_m, wo_m);
    end
  endtask

  task automatic test_back_to_back();
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m} !== {1'b1, 8'h55}) begin
      n_err++;
      $display("FAIL b2b_first: got %b/%h want 1/55", wv_m, wo_m);
    end
    send_word(8'hAA, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, ovf_m, wo_l} !== {1'b1, 8'hAA, 1'b0, 8'h55}) begin
      n_err++;
      $display("FAIL b2b_accept_on_done: got valid=%b m=%h ovf=%b l=%h want 1/aa/0/55",
               wv_m, wo_m, ovf_m, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_sof();
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({bc_m, bc_l, wv_m, ovf_m} !== {4'd1, 4'd1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL sof_restart: got cnt=%0d/%0d valid=%b ovf=%b want 1/1/0/0",
               bc_m, bc_l, wv_m, ovf_m);
    end
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, wo_l} !== {1'b1, 8'h80, 8'h01}) begin
      n_err++;
      $display("FAIL sof_word: got valid=%b m=%h l=%h want 1/80/01", wv_m, wo_m, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_word();
    send_word(8'h7E, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, ovf_m, bc_m, wo_m, wv_l, bc_l, wo_l} !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got valid=%b ovf=%b cnt=%0d word=%h l=%b/%0d/%h want 0",
               wv_m, ovf_m, bc_m, wo_m, wv_l, bc_l, wo_l);
    end
    send_word(8'hC3, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if ({wv_m, wo_m, wo_l} !== {1'b1, 8'hC3, 8'hC3}) begin
      n_err++;
      $display("FAIL reset_residue: got valid=%b m=%h l=%h want 1/c3/c3", wv_m, wo_m, wo_l);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic r, sv, si, sf, rdy, clr;
    for (int n = 0; n < 1500; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      sv  = ($urandom_range(0, 3) != 0);
      si  = 1'($urandom_range(0, 1));
      sf  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 9) == 0);
      step(r, sv, si, sf, rdy, clr);
      n_cmp++;
      if ({wv_m, ovf_m, bc_m, wo_m} !== {exp_valid, exp_ovf, 4'(q.size()), exp_word_m}) begin
        n_err++;
        $display("FAIL random_msb cyc %0d: got v=%b o=%b c=%0d w=%h want v=%b o=%b c=%0d w=%h",
                 n, wv_m, ovf_m, bc_m, wo_m, exp_valid, exp_ovf, q.size(), exp_word_m);
      end
      n_cmp++;
      if ({wv_l, ovf_l, bc_l, wo_l} !== {exp_valid, exp_ovf, 4'(q.size()), exp_word_l}) begin
        n_err++;
        $display("FAIL random_lsb cyc %0d: got v=%b o=%b c=%0d w=%h want v=%b o=%b c=%0d w=%h",
                 n, wv_l, ovf_l, bc_l, wo_l, exp_valid, exp_ovf, q.size(), exp_word_l);
      end
    end
  endtask

  initial begin
    res = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; sof = 1'b0; word_ready = 1'b0; ovf_clr = 1'b0;
    exp_word_m = '0; exp_word_l = '0; exp_valid = 1'b0; exp_ovf = 1'b0;
    test_reset();
    test_msb_lsb_order();
    test_overflow();
    test_back_to_back();
    test_sof();
    test_reset_mid_word();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
